// File: rtl/hdc_pkg.sv
// Shared constants and FSM encoding for the HDC classification controller.
package hdc_pkg;

    localparam int MAX_LEN_DEF = 160;
    localparam int CHAR_W_DEF  = 32;
    localparam int LEN_W_DEF   = 8;

    localparam logic SPAM = 1'b1;
    localparam logic HAM  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_STREAM   = 3'd2,
        S_WAIT_SIM = 3'd3,
        S_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/hdc_classify_ctrl_if.sv
// Message-buffer read port and encoder stream between the controller (master)
// and the buffer/encoder side (slave).
interface hdc_classify_ctrl_if #(
    parameter int CHAR_W = hdc_pkg::CHAR_W_DEF,
    parameter int LEN_W  = hdc_pkg::LEN_W_DEF
);
    logic              char_rd_en;
    logic [LEN_W-1:0]  char_addr;
    logic [CHAR_W-1:0] char_data;
    logic              enc_valid;
    logic [CHAR_W-1:0] enc_char;
    logic              enc_last;
    logic              enc_ready;
    logic              enc_clear;

    modport master (
        output char_rd_en, char_addr, enc_valid, enc_char, enc_last, enc_clear,
        input  char_data, enc_ready
    );

    modport slave (
        input  char_rd_en, char_addr, enc_valid, enc_char, enc_last, enc_clear,
        output char_data, enc_ready
    );
endinterface

// File: rtl/hdc_char_fifo.sv
// Two-entry holding FIFO between the message-buffer read port and the encoder stream.
module hdc_char_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/hdc_classify_ctrl.sv
// Sequences one message through encoder clear, character streaming and similarity search.
// Optional statistics counters are enabled by defining HDC_CTRL_STATS_EN.
module hdc_classify_ctrl import hdc_pkg::*; #(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        msg_len,
    hdc_classify_ctrl_if.master     bus,
    output logic                    sim_start,
    input  logic                    sim_done,
    input  logic                    sim_class,
    output logic                    busy,
    output logic                    done,
    output logic                    class_out,
    output logic                    class_valid,
    output logic                    err_len,
    output logic [15:0]             spam_cnt,
    output logic [15:0]             ham_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_addr;
    logic               rd_pend;
    logic               rd_last_pend;
    logic               enc_clear_q;
    logic               len_ok;
    logic               room;
    logic               rd_go;
    logic               xfer;
    logic [CHAR_W:0]    fifo_head;
    logic               fifo_empty;
    logic [1:0]         fifo_count;

    assign len_ok = (msg_len != '0) && (msg_len <= MAX_LEN_L);
    assign xfer   = !fifo_empty && bus.enc_ready;

    // Room counts the slot freed by a same-cycle pop so a ready encoder sees one char per cycle.
    always_comb begin
        room = 1'b0;
        case (fifo_count)
            2'd0:    room = 1'b1;
            2'd1:    room = xfer || !rd_pend;
            2'd2:    room = xfer && !rd_pend;
            default: room = 1'b0;
        endcase
    end

    assign rd_go = (state == S_STREAM) && (rd_addr != len_q) && room;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr      <= '0;
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
        end else begin
            rd_pend      <= rd_go;
            rd_last_pend <= rd_go && (rd_addr == len_q - 1'b1);
            if (state == S_IDLE) begin
                rd_addr <= '0;
            end else if (rd_go) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    hdc_char_fifo #(.W(CHAR_W + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend),
        .push_data ({rd_last_pend, bus.char_data}),
        .pop       (xfer),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.char_rd_en = rd_go;
    assign bus.char_addr  = rd_go ? rd_addr : '0;
    assign bus.enc_valid  = !fifo_empty;
    assign bus.enc_char   = fifo_empty ? '0 : fifo_head[CHAR_W-1:0];
    assign bus.enc_last   = !fifo_empty && fifo_head[CHAR_W];
    assign bus.enc_clear  = enc_clear_q;

    // Pulse outputs default low each cycle and are raised only on the transition that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            enc_clear_q <= 1'b0;
            sim_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_out   <= 1'b0;
            class_valid <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            enc_clear_q <= 1'b0;
            sim_start   <= 1'b0;
            done        <= 1'b0;
            class_valid <= 1'b0;
            err_len     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len_ok) begin
                            len_q       <= msg_len;
                            enc_clear_q <= 1'b1;
                            state       <= S_CLEAR;
                        end else begin
                            err_len <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (xfer && bus.enc_last) begin
                        sim_start <= 1'b1;
                        state     <= S_WAIT_SIM;
                    end
                end
                S_WAIT_SIM: begin
                    if (sim_done) begin
                        class_out   <= sim_class;
                        done        <= 1'b1;
                        class_valid <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HDC_CTRL_STATS_EN
    logic [15:0] spam_q;
    logic [15:0] ham_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spam_q <= '0;
            ham_q  <= '0;
        end else if (class_valid) begin
            if (class_out == SPAM) begin
                if (spam_q != 16'hFFFF) spam_q <= spam_q + 16'd1;
            end else begin
                if (ham_q != 16'hFFFF) ham_q <= ham_q + 16'd1;
            end
        end
    end

    assign spam_cnt = spam_q;
    assign ham_cnt  = ham_q;
`else
    assign spam_cnt = '0;
    assign ham_cnt  = '0;
`endif

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Scoreboard bench for hdc_classify_ctrl: directed messages push expected reads,
// characters and results; a negedge monitor pops and compares.
module tb_hdc_classify_ctrl;
    import hdc_pkg::*;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } char_exp_t;

    typedef struct packed {
        logic err;
        logic cv;
        logic cls;
    } res_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [7:0]  msg_len = '0;
    logic        sim_start;
    logic        sim_done = 1'b0;
    logic        sim_class = 1'b0;
    logic        busy, done, class_out, class_valid, err_len;
    logic [15:0] spam_cnt, ham_cnt;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int rd_cnt = 0, clear_cnt = 0, sim_start_cnt = 0, done_cnt = 0, xfer_cnt = 0;
    int clear_cycle = 0, last_xfer_cycle = 0, xfer_in_msg = 0;
    bit first_pending = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_done = 1'b0;
    logic [32:0] prev_word = '0;
    bit stall_mode = 1'b0;

    logic [7:0] exp_addrs [$];
    char_exp_t  exp_chars [$];
    res_exp_t   exp_results [$];

    hdc_classify_ctrl_if #(.CHAR_W(32), .LEN_W(8)) bus ();

    hdc_classify_ctrl #(.MAX_LEN(160), .CHAR_W(32), .LEN_W(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .msg_len     (msg_len),
        .bus         (bus),
        .sim_start   (sim_start),
        .sim_done    (sim_done),
        .sim_class   (sim_class),
        .busy        (busy),
        .done        (done),
        .class_out   (class_out),
        .class_valid (class_valid),
        .err_len     (err_len),
        .spam_cnt    (spam_cnt),
        .ham_cnt     (ham_cnt)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL timeout waiting for %s", name);
    endfunction

    function automatic void checkAllZero(input string tag);
        checkOutput({tag, "_flags"}, {54'd0, busy, done, class_out, class_valid, err_len,
                    sim_start, bus.enc_clear, bus.char_rd_en, bus.enc_valid, bus.enc_last}, 64'd0);
        checkOutput({tag, "_enc_char"}, {32'd0, bus.enc_char}, 64'd0);
        checkOutput({tag, "_char_addr"}, {56'd0, bus.char_addr}, 64'd0);
        checkOutput({tag, "_stats"}, {32'd0, spam_cnt, ham_cnt}, 64'd0);
    endfunction

    // Message buffer model: word i holds C0DE_00ii, returned one cycle after the read.
    always @(posedge clk) begin
        if (bus.char_rd_en) bus.char_data <= 32'hC0DE_0000 | {24'd0, bus.char_addr};
    end

    initial begin
        bus.char_data = '0;
        bus.enc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.enc_ready = stall_mode ? ~bus.enc_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a read, transfer or result.
    always @(negedge clk) begin
        char_exp_t c;
        res_exp_t  r;
        cycle++;
        if (!rst_n) begin
            exp_addrs.delete();
            exp_chars.delete();
            exp_results.delete();
            first_pending = 1'b0;
            prev_stall = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus.char_rd_en) begin
                rd_cnt++;
                if (exp_addrs.size() == 0) timeoutFail("unexpected_read");
                else checkOutput("char_addr", {56'd0, bus.char_addr}, {56'd0, exp_addrs.pop_front()});
            end
            if (bus.enc_clear) begin
                clear_cnt++;
                clear_cycle = cycle;
                first_pending = 1'b1;
                xfer_in_msg = 0;
            end
            if (bus.enc_valid && first_pending) begin
                first_pending = 1'b0;
                checkOutput("first_valid_latency", 64'(cycle - clear_cycle), 64'd3);
            end
            if (prev_stall)
                checkOutput("stall_hold", {30'd0, bus.enc_valid, bus.enc_last, bus.enc_char},
                            {30'd0, 1'b1, prev_word});
            if (bus.enc_valid && bus.enc_ready) begin
                xfer_cnt++;
                if (exp_chars.size() == 0) timeoutFail("unexpected_char");
                else begin
                    c = exp_chars.pop_front();
                    checkOutput("enc_char", {31'd0, bus.enc_last, bus.enc_char}, {31'd0, c});
                end
                if (!stall_mode && xfer_in_msg > 0)
                    checkOutput("throughput_gap", 64'(cycle - last_xfer_cycle), 64'd1);
                last_xfer_cycle = cycle;
                xfer_in_msg++;
            end
            if (sim_start) sim_start_cnt++;
            if (done) begin
                done_cnt++;
                checkOutput("done_pulse_prev", {63'd0, prev_done}, 64'd0);
                if (exp_results.size() == 0) timeoutFail("unexpected_done");
                else begin
                    r = exp_results.pop_front();
                    checkOutput("err_len", {63'd0, err_len}, {63'd0, r.err});
                    checkOutput("class_valid", {63'd0, class_valid}, {63'd0, r.cv});
                    if (r.cv) checkOutput("class_out", {63'd0, class_out}, {63'd0, r.cls});
                end
            end
            prev_done = done;
            prev_stall = bus.enc_valid && !bus.enc_ready;
            prev_word = {bus.enc_last, bus.enc_char};
        end
    end

    task automatic pulseStart(input logic [7:0] len);
        @(posedge clk);
        #1 start = 1'b1;
        msg_len = len;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pushExpect(input int len, input bit cls);
        if (len >= 1 && len <= 160) begin
            for (int i = 0; i < len; i++) begin
                exp_addrs.push_back(i[7:0]);
                exp_chars.push_back('{last: (i == len - 1), data: 32'hC0DE_0000 | 32'(i)});
            end
            exp_results.push_back('{err: 1'b0, cv: 1'b1, cls: cls});
        end else begin
            exp_results.push_back('{err: 1'b1, cv: 1'b0, cls: 1'b0});
        end
    endtask

    task automatic applyStimulus(input int len, input bit cls, input bit stall, input bit poke);
        int  n;
        bit  seen;
        int  done0;
        stall_mode = stall;
        pushExpect(len, cls);
        done0 = done_cnt;
        pulseStart(len[7:0]);
        if (len >= 1 && len <= 160) begin
            seen = 1'b0;
            for (n = 0; n < 2000 && !seen; n++) begin
                @(negedge clk);
                seen = sim_start;
            end
            if (!seen) timeoutFail("sim_start");
            else begin
                if (poke) pulseStart(8'd2);
                repeat (5) @(posedge clk);
                #1 sim_done = 1'b1;
                sim_class = cls;
                @(posedge clk);
                #1 sim_done = 1'b0;
            end
        end
        n = 0;
        while (done_cnt == done0 && n < 2000) begin
            @(negedge clk);
            #1 n++;
        end
        if (done_cnt == done0) timeoutFail("done");
        repeat (2) @(posedge clk);
        stall_mode = 1'b0;
    endtask

    initial begin
        int rd0, clr0, ss0, d0, n, base;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] len=3 spam, ready high");
        applyStimulus(3, SPAM, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("class_out_hold", {63'd0, class_out}, 64'd1);

        $display("[TB] len=4 ham, ready toggling");
        applyStimulus(4, HAM, 1'b1, 1'b0);

        $display("[TB] length errors");
        rd0 = rd_cnt; clr0 = clear_cnt; ss0 = sim_start_cnt;
        applyStimulus(0, HAM, 1'b0, 1'b0);
        applyStimulus(161, HAM, 1'b0, 1'b0);
        checkOutput("err_no_reads", 64'(rd_cnt - rd0), 64'd0);
        checkOutput("err_no_clear", 64'(clear_cnt - clr0), 64'd0);
        checkOutput("err_no_sim_start", 64'(sim_start_cnt - ss0), 64'd0);

        $display("[TB] sim_done while idle");
        d0 = done_cnt;
        @(posedge clk);
        #1 sim_done = 1'b1;
        @(posedge clk);
        #1 sim_done = 1'b0;
        repeat (5) @(posedge clk);
        checkOutput("idle_sim_done_ignored", 64'(done_cnt - d0), 64'd0);

        $display("[TB] start during WAIT_SIM");
        d0 = done_cnt; clr0 = clear_cnt;
        applyStimulus(5, SPAM, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        checkOutput("poke_single_done", 64'(done_cnt - d0), 64'd1);
        checkOutput("poke_single_clear", 64'(clear_cnt - clr0), 64'd1);

        $display("[TB] reset mid-stream");
        stall_mode = 1'b0;
        pushExpect(160, SPAM);
        base = xfer_cnt;
        pulseStart(8'd160);
        n = 0;
        while (xfer_cnt < base + 80 && n < 1000) begin
            @(negedge clk);
            #1 n++;
        end
        if (xfer_cnt < base + 80) timeoutFail("char_80");
        rst_n = 1'b0;
        #1 checkAllZero("mid_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ss0 = sim_start_cnt; d0 = done_cnt;
        repeat (10) @(posedge clk);
        checkOutput("post_reset_no_sim_start", 64'(sim_start_cnt - ss0), 64'd0);
        checkOutput("post_reset_no_done", 64'(done_cnt - d0), 64'd0);
        applyStimulus(2, HAM, 1'b0, 1'b0);

        $display("[TB] statistics");
        applyStimulus(1, SPAM, 1'b0, 1'b0);
        applyStimulus(2, SPAM, 1'b0, 1'b0);
        applyStimulus(3, HAM, 1'b1, 1'b0);
        applyStimulus(1, SPAM, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
`ifdef HDC_CTRL_STATS_EN
        checkOutput("spam_cnt", {48'd0, spam_cnt}, 64'd3);
        checkOutput("ham_cnt", {48'd0, ham_cnt}, 64'd2);
`else
        checkOutput("spam_cnt", {48'd0, spam_cnt}, 64'd0);
        checkOutput("ham_cnt", {48'd0, ham_cnt}, 64'd0);
`endif

        checkOutput("addr_queue_empty", 64'(exp_addrs.size()), 64'd0);
        checkOutput("char_queue_empty", 64'(exp_chars.size()), 64'd0);
        checkOutput("result_queue_empty", 64'(exp_results.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
